// File: rtl/serial_four_bit_comparator_if.sv
// serial_four_bit_comparator_if: operand/result handshake bundle for the serial comparator
interface serial_four_bit_comparator_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] A;
    logic [3:0] B;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] R;
    logic       busy;
    logic [7:0] cmp_count;
    modport master (output in_valid, A, B, out_ready, input in_ready, out_valid, R, busy, cmp_count);
    modport slave (input in_valid, A, B, out_ready, output in_ready, out_valid, R, busy, cmp_count);
endinterface

// File: rtl/serial_four_bit_comparator.sv
// serial_four_bit_comparator: bit-serial MSB-first unsigned compare, R={gt,lt,eq,ne}; define EARLY_EXIT_EN to finish on the first differing bit
module serial_four_bit_comparator (
    input logic clk,
    input logic rst,
    serial_four_bit_comparator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state;
    logic [3:0] a_sh, b_sh;
    logic [1:0] idx;
    logic gt, lt, gt_n, lt_n, last;
    // flag update from the current MSB pair; a decided flag blocks any later change
    always_comb begin
        gt_n = gt | (~gt & ~lt & a_sh[3] & ~b_sh[3]);
        lt_n = lt | (~gt & ~lt & ~a_sh[3] & b_sh[3]);
`ifdef EARLY_EXIT_EN
        last = (idx == 2'd0) | gt_n | lt_n;
`else
        last = idx == 2'd0;
`endif
    end
    // control FSM with registered handshake outputs and result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            a_sh          <= 4'd0;
            b_sh          <= 4'd0;
            idx           <= 2'd0;
            gt            <= 1'b0;
            lt            <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.R         <= 4'd0;
            bus.busy      <= 1'b0;
            bus.cmp_count <= 8'd0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_sh         <= bus.A;
                    b_sh         <= bus.B;
                    gt           <= 1'b0;
                    lt           <= 1'b0;
                    idx          <= 2'd3;
                    state        <= SHIFT;
                    bus.in_ready <= 1'b0;
                    bus.busy     <= 1'b1;
                end
                SHIFT: begin
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh << 1;
                    gt   <= gt_n;
                    lt   <= lt_n;
                    idx  <= idx - 2'd1;
                    if (last) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.R         <= {gt_n, lt_n, ~gt_n & ~lt_n, gt_n | lt_n};
                    end
                end
                DONE: if (bus.out_ready) begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                    bus.R         <= 4'd0;
                    bus.busy      <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    bus.cmp_count <= bus.cmp_count + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_four_bit_comparator.sv
// tb_serial_four_bit_comparator: directed vectors with queued expectations checked by an independent monitor
module tb_serial_four_bit_comparator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [3:0] exp_q[$];
`ifdef EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    serial_four_bit_comparator_if bus ();
    serial_four_bit_comparator dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp_v, cyc);
        end
    endfunction

    function automatic int lat_of(input logic [3:0] a, input logic [3:0] b);
        if (EE)
            for (int k = 3; k >= 0; k--)
                if (a[k] != b[k]) return 4 - k;
        return 4;
    endfunction

    // monitor: consumes one expectation per delivered result, checks R is zero when not valid
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_result", int'(bus.R), -1);
                else chk("R", int'(bus.R), int'(exp_q.pop_front()));
            end else if (!bus.out_valid) chk("R_zero_when_idle", int'(bus.R), 0);
        end
    end

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] r,
                        input int lat, input logic rdy, output int acc);
        int n = 0;
        while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
        chk("in_ready_wait", int'(bus.in_ready), 1);
        exp_q.push_back(r);
        bus.A = a;
        bus.B = b;
        bus.in_valid = 1'b1;
        bus.out_ready = rdy;
        @(negedge clk);
        acc = cyc;
        bus.in_valid = 1'b0;
        bus.A = 4'd0;
        bus.B = 4'd0;
        n = 0;
        while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
        chk("latency", n, lat);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, prev, prev_lat;
        logic [7:0] v;
        logic [3:0] a, b;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.A = 4'd0;
        bus.B = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_R", int'(bus.R), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_count", int'(bus.cmp_count), 0);
        rst = 1'b0;
        send(4'b0101, 4'b1010, 4'b0101, EE ? 1 : 4, 1'b1, acc);
        @(negedge clk);
        chk("count_t1", int'(bus.cmp_count), 1);
        chk("in_ready_t1", int'(bus.in_ready), 1);
        send(4'b1100, 4'b1100, 4'b0010, 4, 1'b1, acc);
        @(negedge clk);
        chk("count_t2", int'(bus.cmp_count), 2);
        send(4'b1100, 4'b1010, 4'b1001, EE ? 2 : 4, 1'b0, acc);
        for (int i = 0; i < 5; i++) begin
            chk("hold_out_valid", int'(bus.out_valid), 1);
            chk("hold_R", int'(bus.R), 4'b1001);
            chk("hold_in_ready", int'(bus.in_ready), 0);
            chk("hold_busy", int'(bus.busy), 1);
            bus.in_valid = 1'b1;
            bus.A = 4'b1111;
            bus.B = 4'b0000;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("count_t3", int'(bus.cmp_count), 3);
        chk("busy_after_t3", int'(bus.busy), 0);
        @(negedge clk);
        chk("ignored_second_valid", int'(bus.busy), 0);
        send(4'b0111, 4'b1110, 4'b0101, EE ? 1 : 4, 1'b1, acc);
        @(negedge clk);
        chk("count_t4", int'(bus.cmp_count), 4);
        bus.A = 4'b1000;
        bus.B = 4'b0111;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_in_ready", int'(bus.in_ready), 1);
        chk("abort_out_valid", int'(bus.out_valid), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_count", int'(bus.cmp_count), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("abort_no_result", int'(bus.out_valid), 0);
            @(negedge clk);
        end
        chk("abort_count_after", int'(bus.cmp_count), 0);
        prev = 0;
        prev_lat = 4;
        for (int i = 0; i < 256; i++) begin
            v = i[7:0];
            a = v[3:0];
            b = v[7:4] ^ 4'b0110;
            if (i == 255) begin
                @(negedge clk);
                chk("count_255", int'(bus.cmp_count), 255);
            end
            send(a, b, {a > b, a < b, a == b, a != b}, lat_of(a, b), 1'b1, acc);
            if (i > 0 && i < 255) chk("issue_interval", acc - prev, prev_lat + 2);
            prev = acc;
            prev_lat = lat_of(a, b);
        end
        @(negedge clk);
        chk("count_wrap", int'(bus.cmp_count), 0);
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
